// File: rtl/run_arb_ctrl_if.sv
// Request/grant/status bundle for run_arb_ctrl.
// Optional evt_cnt bus is present only when RUN_ARB_STATS_EN is defined.
interface run_arb_ctrl_if;
  logic [3:0] req;
  logic [3:0] bit_in;
  logic [3:0] clr_ch;
  logic [3:0] gnt;
  logic [3:0] run_flag;
  logic [3:0] run_val;
`ifdef RUN_ARB_STATS_EN
  logic [31:0] evt_cnt;

  modport master (output req, bit_in, clr_ch, input gnt, run_flag, run_val, evt_cnt);
  modport slave  (input req, bit_in, clr_ch, output gnt, run_flag, run_val, evt_cnt);
`else
  modport master (output req, bit_in, clr_ch, input gnt, run_flag, run_val);
  modport slave  (input req, bit_in, clr_ch, output gnt, run_flag, run_val);
`endif
endinterface

// File: rtl/run_arb_ctrl.sv
// Four-channel round-robin arbiter feeding per-channel run-length detectors.
// Define RUN_ARB_STATS_EN to add per-channel run-event counters on evt_cnt.
module run_arb_ctrl #(
  parameter int unsigned THRESH = 3,
  parameter int unsigned CNT_W  = 4
) (
  input  logic          clk,
  input  logic          reset,
  run_arb_ctrl_if.slave bus
);

  localparam int unsigned N_CH  = 4;
  localparam int unsigned PTR_W = 2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {ST_EMPTY, ST_COUNT, ST_RUN} ch_state_e;

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_idx;
  logic [PTR_W-1:0] w_gidx;
  logic [N_CH-1:0]  w_elig;
  logic [N_CH-1:0]  w_gnt;

  assign w_elig  = bus.req & ~bus.clr_ch;
  assign bus.gnt = w_gnt;

  // First eligible channel at or after r_ptr wins; reset forces no grant.
  always_comb begin
    w_gnt  = '0;
    w_gidx = r_ptr;
    w_idx  = r_ptr;
    for (int unsigned k = 0; k < N_CH; k++) begin
      w_idx = r_ptr + PTR_W'(k);
      if ((w_gnt == '0) && w_elig[w_idx] && !reset) begin
        w_gnt[w_idx] = 1'b1;
        w_gidx       = w_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (w_gnt != '0) begin
      r_ptr <= w_gidx + PTR_W'(1);
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    ch_state_e        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_last;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_run_nxt;

    // A sample extends the run only if it repeats the last consumed bit.
    always_comb begin
      w_cnt_nxt = CNT_W'(1);
      if ((r_state != ST_EMPTY) && (bus.bit_in[g] == r_last)) begin
        w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
      end
    end

    assign w_run_nxt = (w_cnt_nxt >= CNT_W'(THRESH));

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_state <= ST_EMPTY;
        r_cnt   <= '0;
        r_last  <= 1'b0;
      end else if (bus.clr_ch[g]) begin
        r_state <= ST_EMPTY;
        r_cnt   <= '0;
        r_last  <= 1'b0;
      end else if (w_gnt[g]) begin
        r_state <= w_run_nxt ? ST_RUN : ST_COUNT;
        r_cnt   <= w_cnt_nxt;
        r_last  <= bus.bit_in[g];
      end
    end

    assign bus.run_flag[g] = (r_state == ST_RUN);
    assign bus.run_val[g]  = r_last;

`ifdef RUN_ARB_STATS_EN
    logic [7:0] r_evt;

    // Counts entries into RUN, saturating.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_evt <= '0;
      end else if (bus.clr_ch[g]) begin
        r_evt <= '0;
      end else if (w_gnt[g] && w_run_nxt && (r_state != ST_RUN) && (r_evt != 8'hFF)) begin
        r_evt <= r_evt + 8'd1;
      end
    end

    assign bus.evt_cnt[8*g +: 8] = r_evt;
`endif
  end

endmodule

// File: tb/tb_run_arb_ctrl.sv
// Directed bench for run_arb_ctrl with a per-cycle behavioural model.
// Build with RUN_ARB_STATS_EN defined to also check evt_cnt.
module tb_run_arb_ctrl;

  localparam int THRESH = 3;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  run_arb_ctrl_if bus ();

  run_arb_ctrl #(.THRESH(THRESH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [3:0] last_gnt;

  // Model state: plain integers per channel.
  int         m_cnt [4];
  int         m_evt [4];
  logic [3:0] m_last = '0;
  logic [3:0] m_flag = '0;
  int         m_ptr  = 0;
  logic [3:0] mg;
  int         nc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_gnt();
    logic [3:0] g;
    int c;
    g = '0;
    if (reset) return g;
    for (int k = 0; k < 4; k++) begin
      c = (m_ptr + k) % 4;
      if (bus.req[c] && !bus.clr_ch[c]) begin
        g[c] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ptr  <= 0;
      m_last <= '0;
      m_flag <= '0;
      for (int c = 0; c < 4; c++) begin
        m_cnt[c] <= 0;
        m_evt[c] <= 0;
      end
    end else begin
      mg = exp_gnt();
      for (int c = 0; c < 4; c++) begin
        if (bus.clr_ch[c]) begin
          m_cnt[c]  <= 0;
          m_evt[c]  <= 0;
          m_last[c] <= 1'b0;
          m_flag[c] <= 1'b0;
        end else if (mg[c]) begin
          nc = (m_cnt[c] != 0 && bus.bit_in[c] == m_last[c]) ? m_cnt[c] + 1 : 1;
          if (nc > CMAX) nc = CMAX;
          m_cnt[c]  <= nc;
          m_last[c] <= bus.bit_in[c];
          m_flag[c] <= (nc >= THRESH);
          if (nc >= THRESH && !m_flag[c] && m_evt[c] < 255) m_evt[c] <= m_evt[c] + 1;
        end
        if (mg[c]) m_ptr <= (c + 1) % 4;
      end
    end
  end

  // Compare DUT to model mid-cycle, away from the active edge.
  always @(negedge clk) begin
    chk("gnt", 32'(bus.gnt), 32'(exp_gnt()));
    chk("run_flag", 32'(bus.run_flag), 32'(m_flag));
    chk("run_val", 32'(bus.run_val), 32'(m_last));
`ifdef RUN_ARB_STATS_EN
    chk("evt_cnt", bus.evt_cnt, {8'(m_evt[3]), 8'(m_evt[2]), 8'(m_evt[1]), 8'(m_evt[0])});
`endif
  end

  task automatic cyc(input logic [3:0] r, input logic [3:0] b, input logic [3:0] c);
    bus.req    = r;
    bus.bit_in = b;
    bus.clr_ch = c;
    @(negedge clk);
    #1 last_gnt = bus.gnt;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(4'b0000, 4'b0000, 4'b0000);
    reset = 1'b0;
  endtask

  logic [3:0] seq [8];

  initial begin
    bus.req = '0; bus.bit_in = '0; bus.clr_ch = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_flag", 32'(bus.run_flag), 32'h0);
    chk("reset_val", 32'(bus.run_val), 32'h0);
    reset = 1'b0;

    // Three zeros on channel 0 reach THRESH.
    cyc(4'b0001, 4'b0000, 4'b0000);
    chk("ch0_first_gnt", 32'(last_gnt), 32'h1);
    cyc(4'b0001, 4'b0000, 4'b0000);
    chk("ch0_two_noflag", 32'(bus.run_flag), 32'h0);
    cyc(4'b0001, 4'b0000, 4'b0000);
    chk("ch0_run_flag", 32'(bus.run_flag), 32'h1);
    chk("ch0_run_val", 32'(bus.run_val), 32'h0);

    // All four requesting: strict rotation, two samples each.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(4'b1111, 4'b1111, 4'b0000);
      seq[i] = last_gnt;
    end
    chk("rr_g0", 32'(seq[0]), 32'h1);
    chk("rr_g1", 32'(seq[1]), 32'h2);
    chk("rr_g2", 32'(seq[2]), 32'h4);
    chk("rr_g3", 32'(seq[3]), 32'h8);
    chk("rr_g4", 32'(seq[4]), 32'h1);
    chk("rr_g7", 32'(seq[7]), 32'h8);
    chk("rr_flag_cnt2", 32'(bus.run_flag), 32'h0);
    chk("rr_val", 32'(bus.run_val), 32'hF);
    cyc(4'b1111, 4'b1111, 4'b0000);
    chk("rr_third_ch0", 32'(bus.run_flag), 32'h1);

    // Channel 1 run broken by a differing bit.
    do_reset();
    repeat (4) cyc(4'b0010, 4'b0010, 4'b0000);
    chk("ch1_run", 32'(bus.run_flag), 32'h2);
    chk("ch1_val", 32'(bus.run_val), 32'h2);
    cyc(4'b0010, 4'b0000, 4'b0000);
    chk("ch1_break_flag", 32'(bus.run_flag), 32'h0);
    chk("ch1_break_val", 32'(bus.run_val), 32'h0);

    // Long run on channel 2 saturates, single run event.
    do_reset();
    repeat (20) cyc(4'b0100, 4'b0100, 4'b0000);
    chk("ch2_sat_flag", 32'(bus.run_flag), 32'h4);
`ifdef RUN_ARB_STATS_EN
    chk("ch2_evt", 32'(bus.evt_cnt[23:16]), 32'h1);
`endif
    cyc(4'b0100, 4'b0100, 4'b0100);
    chk("clr_blocks_gnt", 32'(last_gnt), 32'h0);
    chk("clr_flag", 32'(bus.run_flag), 32'h0);
    chk("clr_val", 32'(bus.run_val), 32'h0);

    // Skipping idle channels, idle hold, masked requester.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(4'b0101, 4'b0000, 4'b0000);
      seq[i] = last_gnt;
    end
    chk("skip_g0", 32'(seq[0]), 32'h1);
    chk("skip_g1", 32'(seq[1]), 32'h4);
    chk("skip_g2", 32'(seq[2]), 32'h1);
    cyc(4'b0000, 4'b0000, 4'b0000);
    cyc(4'b1111, 4'b0000, 4'b0001);
    chk("masked_gnt", 32'(last_gnt), 32'h2);
    cyc(4'b1001, 4'b0000, 4'b0000);
    chk("after_mask_gnt", 32'(last_gnt), 32'h8);

    // Reset asserted mid-run clears everything at once.
    do_reset();
    repeat (3) cyc(4'b0001, 4'b0001, 4'b0000);
    chk("pre_rst_flag", 32'(bus.run_flag), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("midrst_gnt", 32'(bus.gnt), 32'h0);
    chk("midrst_flag", 32'(bus.run_flag), 32'h0);
    chk("midrst_val", 32'(bus.run_val), 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) cyc(4'b0001, 4'b0001, 4'b0000);
    chk("post_rst_cnt2", 32'(bus.run_flag), 32'h0);
    chk("post_rst_val", 32'(bus.run_val), 32'h1);
    cyc(4'b0000, 4'b0000, 4'b0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
